// File: rtl/gene_net_sim.sv
// gene_net_sim: Boolean gene-regulatory-network engine.
// Each gene has a programmable activator/inhibitor mask pair. The engine
// supports loading a state, single-stepping, and autonomous runs that look
// for an attractor using Brent's cycle-detection algorithm.
// Optional feature macro: GENE_NET_DEFAULT_RULES_EN (reset loads the
// reference 8-gene rule set instead of all-zero masks).
//
// Handshake: load, step, start and cfg_we are level-sampled single-cycle
// commands. They are accepted on any rising edge while not busy and ignored
// while busy. done/found/timeout/period/steps are valid while done is high.
module gene_net_sim #(
    parameter int N      = 8,
    parameter int STEP_W = 16,
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [N-1:0]      cfg_act,
    input  logic [N-1:0]      cfg_inh,
    input  logic              load,
    input  logic [N-1:0]      load_state,
    input  logic              step,
    input  logic              start,
    input  logic [STEP_W-1:0] max_steps,
    output logic [N-1:0]      state,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              timeout,
    output logic [STEP_W-1:0] period,
    output logic [STEP_W-1:0] steps,
    output logic [1:0]        dbg_fsm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t fsm_q, fsm_nxt;

    logic [N-1:0]      act_q [N];
    logic [N-1:0]      inh_q [N];
    logic [N-1:0]      state_q;
    logic [N-1:0]      saved_q;
    logic [N-1:0]      nxt;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] period_q;
    logic [STEP_W-1:0] power_q;
    logic [STEP_W-1:0] lam_q;
    logic [STEP_W-1:0] steps_inc;
    logic [STEP_W-1:0] lam_inc;
    logic              busy_q, done_q, found_q, timeout_q;

    logic cfg_ok, do_load, do_start, do_step;
    logic run_found, run_tout, run_save, tout_hit;

`ifdef GENE_NET_DEFAULT_RULES_EN
    // Reference 8-gene network; bit i of each mask refers to gene i.
    function automatic logic [N-1:0] dflt_act(input int i);
        logic [7:0] t;
        case (i)
            0: t = 8'h40;
            1: t = 8'h30;
            2: t = 8'h80;
            3: t = 8'h02;
            4: t = 8'h0A;
            5: t = 8'h04;
            6: t = 8'h02;
            7: t = 8'h48;
            default: t = 8'h00;
        endcase
        return (N >= 8) ? N'(t) : '0;
    endfunction

    function automatic logic [N-1:0] dflt_inh(input int i);
        logic [7:0] t;
        case (i)
            0: t = 8'h84;
            1: t = 8'h80;
            3: t = 8'h40;
            5: t = 8'h80;
            6: t = 8'h80;
            7: t = 8'h03;
            default: t = 8'h00;
        endcase
        return (N >= 8) ? N'(t) : '0;
    endfunction
`endif

    assign steps_inc = steps_q + 1'b1;
    assign lam_inc   = lam_q + 1'b1;

    // Network update: a gene with an empty activator mask is constitutively
    // active; any active inhibitor forces it off.
    always_comb begin
        nxt = '0;
        for (int i = 0; i < N; i++) begin
            nxt[i] = ((act_q[i] == '0) || (|(state_q & act_q[i])))
                     && !(|(state_q & inh_q[i]));
        end
    end

    // Run termination: explicit limit, or the step counter about to saturate.
    assign tout_hit = ((max_steps != '0) && (steps_inc == max_steps))
                      || (steps_inc == '1);

    // Next-state and command decode; commands only act outside RUN.
    always_comb begin
        fsm_nxt   = fsm_q;
        cfg_ok    = 1'b0;
        do_load   = 1'b0;
        do_start  = 1'b0;
        do_step   = 1'b0;
        run_found = 1'b0;
        run_tout  = 1'b0;
        run_save  = 1'b0;
        case (fsm_q)
            IDLE, DONE: begin
                cfg_ok = cfg_we && (int'(cfg_idx) < N);
                if (load) begin
                    do_load = 1'b1;
                    fsm_nxt = IDLE;
                end else if (start) begin
                    do_start = 1'b1;
                    fsm_nxt  = RUN;
                end else if (step) begin
                    do_step = 1'b1;
                    fsm_nxt = IDLE;
                end
            end
            RUN: begin
                if (nxt == saved_q) begin
                    run_found = 1'b1;
                    fsm_nxt   = DONE;
                end else if (tout_hit) begin
                    run_tout = 1'b1;
                    fsm_nxt  = DONE;
                end else if (lam_inc == power_q) begin
                    run_save = 1'b1;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // State register, rule storage and run datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            saved_q   <= '0;
            steps_q   <= '0;
            period_q  <= '0;
            power_q   <= '0;
            lam_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
`ifdef GENE_NET_DEFAULT_RULES_EN
                act_q[i] <= dflt_act(i);
                inh_q[i] <= dflt_inh(i);
`else
                act_q[i] <= '0;
                inh_q[i] <= '0;
`endif
            end
        end else begin
            fsm_q <= fsm_nxt;
            if (cfg_ok) begin
                act_q[cfg_idx] <= cfg_act;
                inh_q[cfg_idx] <= cfg_inh;
            end
            if (do_load) begin
                state_q   <= load_state;
                steps_q   <= '0;
                done_q    <= 1'b0;
                found_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else if (do_start) begin
                saved_q   <= state_q;
                power_q   <= STEP_W'(1);
                lam_q     <= '0;
                steps_q   <= '0;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                found_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else if (do_step) begin
                state_q <= nxt;
                done_q  <= 1'b0;
                if (steps_q != '1) begin
                    steps_q <= steps_inc;
                end
            end
            if (fsm_q == RUN) begin
                state_q <= nxt;
                steps_q <= steps_inc;
                lam_q   <= lam_inc;
                if (run_found) begin
                    found_q  <= 1'b1;
                    period_q <= lam_inc;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end else if (run_tout) begin
                    timeout_q <= 1'b1;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                end else if (run_save) begin
                    saved_q <= nxt;
                    lam_q   <= '0;
                    if (!power_q[STEP_W-1]) begin
                        power_q <= power_q << 1;
                    end
                end
            end
        end
    end

    assign state   = state_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign found   = found_q;
    assign timeout = timeout_q;
    assign period  = period_q;
    assign steps   = steps_q;
    assign dbg_fsm = fsm_q;

endmodule

// File: tb/tb_gene_net_sim.sv
// Directed testbench for gene_net_sim (N=8, default build with cleared masks).
module tb_gene_net_sim;

    localparam int N      = 8;
    localparam int STEP_W = 16;
    localparam int IDX_W  = 3;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [N-1:0]      cfg_act;
    logic [N-1:0]      cfg_inh;
    logic              load;
    logic [N-1:0]      load_state;
    logic              step;
    logic              start;
    logic [STEP_W-1:0] max_steps;
    logic [N-1:0]      state;
    logic              busy;
    logic              done;
    logic              found;
    logic              timeout;
    logic [STEP_W-1:0] period;
    logic [STEP_W-1:0] steps;
    logic [1:0]        dbg_fsm;

    gene_net_sim #(.N(N), .STEP_W(STEP_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_act(cfg_act), .cfg_inh(cfg_inh),
        .load(load), .load_state(load_state), .step(step), .start(start),
        .max_steps(max_steps),
        .state(state), .busy(busy), .done(done), .found(found),
        .timeout(timeout), .period(period), .steps(steps), .dbg_fsm(dbg_fsm)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] traj    [9];
    logic [7:0] act_tbl [8];
    logic [7:0] inh_tbl [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic [7:0] a, input logic [7:0] h);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = IDX_W'(idx);
        cfg_act = a;
        cfg_inh = h;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_pulse(input logic [7:0] v);
        @(negedge clk);
        load       = 1'b1;
        load_state = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic step_pulse();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    // Start a run and count the cycles busy stays high (bounded).
    task automatic run(input logic [STEP_W-1:0] m, input bit disturb, input bit trj,
                       output int cyc);
        @(negedge clk);
        max_steps = m;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 200) begin
            if (disturb && cyc == 2) begin
                cfg_we     = 1'b1;
                cfg_idx    = 3'd2;
                cfg_act    = 8'h00;
                cfg_inh    = 8'hFF;
                load       = 1'b1;
                load_state = 8'hFF;
                step       = 1'b1;
            end else begin
                cfg_we = 1'b0;
                load   = 1'b0;
                step   = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (trj && cyc <= 9) check($sformatf("traj%0d", cyc), 32'(state), 32'(traj[cyc-1]));
        end
        cfg_we = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
    endtask

    task automatic check_result(input string tag, input int cyc, input int exp_cyc,
                                input logic [7:0] st, input bit f, input bit t,
                                input int per, input int stp);
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_done"},    32'(done), 32'd1);
        check({tag, "_found"},   32'(found), 32'(f));
        check({tag, "_timeout"}, 32'(timeout), 32'(t));
        check({tag, "_state"},   32'(state), 32'(st));
        check({tag, "_steps"},   32'(steps), 32'(stp));
        if (f) check({tag, "_period"}, 32'(period), 32'(per));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"},   32'(state), 32'd0);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_done"},    32'(done), 32'd0);
        check({tag, "_found"},   32'(found), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_period"},  32'(period), 32'd0);
        check({tag, "_steps"},   32'(steps), 32'd0);
    endtask

    initial begin
        int cyc;
        traj    = '{8'h04, 8'h20, 8'h02, 8'h58, 8'h93, 8'h1C, 8'hB2, 8'h1C, 8'hB2};
        act_tbl = '{8'h40, 8'h30, 8'h80, 8'h02, 8'h0A, 8'h04, 8'h02, 8'h48};
        inh_tbl = '{8'h84, 8'h80, 8'h00, 8'h40, 8'h00, 8'h80, 8'h80, 8'h03};

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_act = '0; cfg_inh = '0;
        load = 1'b0; load_state = '0; step = 1'b0; start = 1'b0; max_steps = '0;

        do_reset();
        check_zero("reset");

        // Cleared masks: every gene constitutively on.
        load_pulse(8'h00);
        run(16'd0, 1'b0, 1'b0, cyc);
        check_result("s5", cyc, 2, 8'hFF, 1'b1, 1'b0, 1, 2);

        // Rerun, then reset on its first busy cycle.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s5_rerun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("s5_midrun_rst");
        rst = 1'b0;

        for (int g = 0; g < 8; g++) cfg_write(g, act_tbl[g], inh_tbl[g]);

        // Fixed point at all-zero.
        load_pulse(8'h00);
        run(16'd0, 1'b0, 1'b0, cyc);
        check_result("s1", cyc, 1, 8'h00, 1'b1, 1'b0, 1, 1);

        // Period-2 attractor with full trajectory.
        load_pulse(8'h80);
        run(16'd0, 1'b0, 1'b1, cyc);
        check_result("s2", cyc, 9, 8'hB2, 1'b1, 1'b0, 2, 9);
        repeat (3) @(negedge clk);
        check("s2_done_held", 32'(done), 32'd1);
        check("s2_state_held", 32'(state), 32'hB2);

        // Step limit.
        load_pulse(8'h80);
        check("s3_load_clears_done", 32'(done), 32'd0);
        run(16'd4, 1'b0, 1'b0, cyc);
        check_result("s3", cyc, 4, 8'h58, 1'b0, 1'b1, 0, 4);

        // Single stepping.
        load_pulse(8'h80);
        check("s4_load_steps", 32'(steps), 32'd0);
        check("s4_load_timeout", 32'(timeout), 32'd0);
        step_pulse();
        check("s4_step1", 32'(state), 32'h04);
        step_pulse();
        check("s4_step2", 32'(state), 32'h20);
        step_pulse();
        check("s4_step3", 32'(state), 32'h02);
        check("s4_steps", 32'(steps), 32'd3);
        check("s4_done", 32'(done), 32'd0);
        check("s4_busy", 32'(busy), 32'd0);

        // Commands during RUN are ignored.
        load_pulse(8'h80);
        run(16'd0, 1'b1, 1'b1, cyc);
        check_result("s6", cyc, 9, 8'hB2, 1'b1, 1'b0, 2, 9);
        load_pulse(8'h80);
        run(16'd0, 1'b0, 1'b1, cyc);
        check_result("s6_rules", cyc, 9, 8'hB2, 1'b1, 1'b0, 2, 9);

        // Reset clears the programmed masks again.
        do_reset();
        load_pulse(8'h00);
        run(16'd0, 1'b0, 1'b0, cyc);
        check_result("rst_masks", cyc, 2, 8'hFF, 1'b1, 1'b0, 1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
